// File: rtl/auto_manual_counter_if.sv
// Bundle of the switch-side controls and display-side results for auto_manual_counter.
// master drives the controls and switches; slave is the counter itself.
interface auto_manual_counter_if #(
  parameter int WIDTH = 4
);
  logic             auto;
  logic             load;
  logic             pause;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] s_sw;
  logic [WIDTH-1:0] s_op;
  logic             tick;
  logic             tc;
  logic [1:0]       state;

  // All signals are level-sampled on posedge clk; there is no valid/ready
  // handshake: every control is a plain level, every result a registered level
  // or single-cycle strobe (tick, tc).
  modport master (
    output auto, load, pause, dir, sat, s_sw,
    input  s_op, tick, tc, state
  );

  modport slave (
    input  auto, load, pause, dir, sat, s_sw,
    output s_op, tick, tc, state
  );
endinterface

// File: rtl/auto_manual_counter.sv
// Auto/manual display counter: manual mode mirrors the switches, auto mode steps a prescaled
// up/down counter with pause, preload and wrap/saturate. AUTO_MANUAL_PINGPONG_EN selects bounce-at-bounds.
module auto_manual_counter #(
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 30
) (
  input logic                  clk,
  input logic                  rst_n,
  auto_manual_counter_if.slave bus
);
  localparam logic [1:0] ST_MANUAL = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;

  localparam logic [WIDTH-1:0]    MAX_VAL  = '1;
  localparam logic [WIDTH-1:0]    ONE      = WIDTH'(1);
  localparam logic [DIV_BITS-1:0] PRE_ONE  = DIV_BITS'(1);

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    op_q, op_d;
  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic                tick_q, tick_d;
  logic                tc_q, tc_d;
  logic                in_auto;
  logic                up;
  logic                at_bound;
  logic [WIDTH-1:0]    step_val;

`ifdef AUTO_MANUAL_PINGPONG_EN
  logic dir_q, dir_d;
  assign up = dir_q;
`else
  assign up = bus.dir;
`endif

  // Every legal transition collapses to: auto off -> MANUAL, else pause picks HOLD/RUN.
  always_comb begin
    state_d = ST_MANUAL;
    if (bus.auto) state_d = bus.pause ? ST_HOLD : ST_RUN;
  end

  // Encoding 11 falls through to the manual behaviour, as does auto dropping this edge.
  assign in_auto  = bus.auto && ((state_q == ST_RUN) || (state_q == ST_HOLD));
  assign at_bound = up ? (op_q == MAX_VAL) : (op_q == '0);

  always_comb begin
    step_val = up ? (op_q + ONE) : (op_q - ONE);
`ifdef AUTO_MANUAL_PINGPONG_EN
    if (at_bound) step_val = up ? (op_q - ONE) : (op_q + ONE);
`else
    // Wrap is the natural modulo result; only saturation needs overriding.
    if (at_bound && bus.sat) step_val = op_q;
`endif
  end

  always_comb begin
    op_d    = op_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
`ifdef AUTO_MANUAL_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (!in_auto) begin
      op_d    = bus.s_sw;
      presc_d = '0;
`ifdef AUTO_MANUAL_PINGPONG_EN
      dir_d   = bus.dir;
`endif
    end else if (bus.load) begin
      op_d    = bus.s_sw;
      presc_d = '0;
`ifdef AUTO_MANUAL_PINGPONG_EN
      dir_d   = bus.dir;
`endif
    end else if (state_q == ST_RUN) begin
      if (&presc_q) begin
        presc_d = '0;
        op_d    = step_val;
        tick_d  = 1'b1;
        tc_d    = at_bound;
`ifdef AUTO_MANUAL_PINGPONG_EN
        if (at_bound) dir_d = ~dir_q;
`endif
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
      op_q    <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef AUTO_MANUAL_PINGPONG_EN
      dir_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
`ifdef AUTO_MANUAL_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign bus.s_op  = op_q;
  assign bus.tick  = tick_q;
  assign bus.tc    = tc_q;
  assign bus.state = state_q;
endmodule
